// File: rtl/reaction_pkg.sv
// reaction_pkg: shared state encoding, LFSR constants and BCD helpers for the
// reaction-timer controller.
package reaction_pkg;

    localparam int unsigned BCD_W = 4;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shift Fibonacci taps for x^16+x^14+x^13+x^11+1 (bit 0 shifts out).
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_RAND,
        RUN,
        STOPPING,
        SHOW,
        CHEAT,
        TIMEOUT
    } state_t;

    function automatic logic bcd_less(input logic [3*BCD_W-1:0] a,
                                      input logic [3*BCD_W-1:0] b);
        if (a[3*BCD_W-1 -: BCD_W] != b[3*BCD_W-1 -: BCD_W])
            return a[3*BCD_W-1 -: BCD_W] < b[3*BCD_W-1 -: BCD_W];
        if (a[2*BCD_W-1 -: BCD_W] != b[2*BCD_W-1 -: BCD_W])
            return a[2*BCD_W-1 -: BCD_W] < b[2*BCD_W-1 -: BCD_W];
        return a[BCD_W-1:0] < b[BCD_W-1:0];
    endfunction

endpackage

// File: rtl/reaction_lfsr.sv
// reaction_lfsr: free-running 16-bit LFSR; only the low 12 bits leave the
// module since that is all the delay generator consumes.
module reaction_lfsr
    import reaction_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    output logic [11:0] value
);

    logic [15:0] sr;

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            sr <= LFSR_SEED;
        else
            sr <= {^(sr & LFSR_TAPS), sr[15:1]};
    end

    assign value = sr[11:0];

endmodule

// File: rtl/reaction_ctrl.sv
// reaction_ctrl: reaction-timer trial sequencer driving an external BCD
// stopwatch. Define REACTION_BEST_EN to keep a best-time register.
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int unsigned TICK_DVSR     = 50000,
    parameter int unsigned DELAY_MIN_MS  = 2000,
    parameter logic [11:0] TIMEOUT_BCD   = 12'h999,
    parameter int unsigned STOP_WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start_btn,
    input  logic               resp_btn,
    input  logic [BCD_W-1:0]   d2,
    input  logic [BCD_W-1:0]   d1,
    input  logic [BCD_W-1:0]   d0,
    input  logic               done_tick,
    output logic               sw_clr,
    output logic               sw_start,
    output logic               sw_stop,
    output logic               stim_led,
    output logic               cheat,
    output logic               timeout,
    output logic               result_valid,
    output logic [3*BCD_W-1:0] result,
    output logic [3*BCD_W-1:0] best,
    output logic               best_valid
);

    localparam int unsigned PW = (TICK_DVSR > 1) ? $clog2(TICK_DVSR) : 1;
    localparam int unsigned WW = $clog2(STOP_WAIT_MAX + 1);

    state_t             state, next;
    logic [11:0]        lfsr;
    logic [PW-1:0]      presc;
    logic [13:0]        delay;
    logic [WW-1:0]      wait_cnt;
    logic [3*BCD_W-1:0] digits;
    logic               sw_clr_nxt, sw_start_nxt, sw_stop_nxt, stim_nxt;
    logic               set_cheat, set_timeout, latch_res;

    assign digits = {d2, d1, d0};

    reaction_lfsr u_lfsr (
        .clk   (clk),
        .clr   (clr),
        .value (lfsr)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next         = state;
        sw_clr_nxt   = 1'b0;
        sw_start_nxt = 1'b0;
        sw_stop_nxt  = 1'b0;
        stim_nxt     = 1'b0;
        set_cheat    = 1'b0;
        set_timeout  = 1'b0;
        latch_res    = 1'b0;
        case (state)
            IDLE, SHOW, CHEAT, TIMEOUT:
                if (start_btn) next = ARM;
            ARM:
                next = WAIT_RAND;
            WAIT_RAND:
                if (resp_btn)          next = CHEAT;
                else if (delay == '0)  next = RUN;
            RUN:
                if (resp_btn)                   next = STOPPING;
                else if (digits == TIMEOUT_BCD) next = TIMEOUT;
            STOPPING:
                if (done_tick || wait_cnt == WW'(STOP_WAIT_MAX - 1)) next = SHOW;
            default:
                next = IDLE;
        endcase
        // Pulses and flags are registered, so they are decoded from the transition.
        sw_clr_nxt   = (next == ARM);
        sw_start_nxt = (state == WAIT_RAND) && (next == RUN);
        sw_stop_nxt  = (state == RUN) && (next != RUN);
        stim_nxt     = (next == RUN) || (next == STOPPING);
        set_cheat    = (state == WAIT_RAND) && (next == CHEAT);
        set_timeout  = (state == RUN) && (next == TIMEOUT);
        latch_res    = (state == STOPPING) && (next == SHOW);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sw_clr       <= 1'b0;
            sw_start     <= 1'b0;
            sw_stop      <= 1'b0;
            stim_led     <= 1'b0;
            cheat        <= 1'b0;
            timeout      <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            presc        <= '0;
            delay        <= '0;
            wait_cnt     <= '0;
        end else begin
            sw_clr   <= sw_clr_nxt;
            sw_start <= sw_start_nxt;
            sw_stop  <= sw_stop_nxt;
            stim_led <= stim_nxt;
            wait_cnt <= (state == STOPPING) ? wait_cnt + 1'b1 : '0;

            if (state == ARM) begin
                presc <= '0;
                delay <= 14'(DELAY_MIN_MS) + {2'b00, lfsr};
            end else if (state == WAIT_RAND) begin
                if (presc == PW'(TICK_DVSR - 1)) begin
                    presc <= '0;
                    if (delay != '0) delay <= delay - 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end

            if (sw_clr_nxt) begin
                cheat        <= 1'b0;
                timeout      <= 1'b0;
                result_valid <= 1'b0;
                result       <= '0;
            end
            if (set_cheat)   cheat   <= 1'b1;
            if (set_timeout) timeout <= 1'b1;
            if (latch_res) begin
                result       <= digits;
                result_valid <= 1'b1;
            end
        end
    end

`ifdef REACTION_BEST_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            best       <= '0;
            best_valid <= 1'b0;
        end else if (latch_res && (!best_valid || bcd_less(digits, best))) begin
            best       <= digits;
            best_valid <= 1'b1;
        end
    end
`else
    assign best       = '0;
    assign best_valid = 1'b0;
`endif

endmodule

// File: tb/tb_reaction_ctrl.sv
// tb_reaction_ctrl: table-driven and randomized trials against a cycle-level
// model of the trial timing, outcome flags and best-time tracking.
module tb_reaction_ctrl;

    localparam int unsigned TICK = 4;
    localparam int unsigned DMIN = 3;
    localparam int          SWM  = 5;

    localparam int K_RESP = 0, K_TIMEOUT = 1, K_CHEAT = 2, K_ABORT = 3;

    typedef struct {
        int          kind;
        logic [11:0] digits;
        int          run_cycles;
        int          done_dly;
        int          cheat_at;
        logic [2:0]  exp_flags;
        logic [11:0] exp_result;
    } vec_t;

    logic        clk = 1'b0, clr = 1'b1;
    logic        start_btn = 1'b0, resp_btn = 1'b0, done_tick = 1'b0;
    logic [3:0]  d2 = '0, d1 = '0, d0 = '0;
    logic        sw_clr, sw_start, sw_stop, stim_led;
    logic        cheat, timeout, result_valid, best_valid;
    logic [11:0] result, best;

    reaction_ctrl #(
        .TICK_DVSR     (TICK),
        .DELAY_MIN_MS  (DMIN),
        .TIMEOUT_BCD   (12'h999),
        .STOP_WAIT_MAX (SWM)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .start_btn    (start_btn),
        .resp_btn     (resp_btn),
        .d2           (d2),
        .d1           (d1),
        .d0           (d0),
        .done_tick    (done_tick),
        .sw_clr       (sw_clr),
        .sw_start     (sw_start),
        .sw_stop      (sw_stop),
        .stim_led     (stim_led),
        .cheat        (cheat),
        .timeout      (timeout),
        .result_valid (result_valid),
        .result       (result),
        .best         (best),
        .best_valid   (best_valid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [15:0] m_lfsr;
    logic [11:0] m_best;
    logic        m_bv;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic fb;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {fb, v[15:1]};
    endfunction

    always @(posedge clk or posedge clr) begin
        if (clr) m_lfsr <= 16'hACE1;
        else     m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [18:0] obs();
        return {sw_clr, sw_start, sw_stop, stim_led, cheat, timeout, result_valid, result};
    endfunction

    function automatic logic [18:0] pk(input logic c, input logic s, input logic p,
                                       input logic l, input logic [2:0] f,
                                       input logic [11:0] r);
        return {c, s, p, l, f, r};
    endfunction

    task automatic check_best(input string tag);
`ifdef REACTION_BEST_EN
        check({tag, "/best"}, {19'd0, best_valid, best}, {19'd0, m_bv, m_best});
`else
        check({tag, "/best"}, {19'd0, best_valid, best}, 32'd0);
`endif
    endtask

    task automatic run_trial(input vec_t v, input string tag);
        logic [15:0] nx;
        int          n, dly, ca, k;
        logic        done_in;
        {d2, d1, d0} = 12'h000;
        n  = 0;
        nx = lfsr_step(m_lfsr);
        while (nx[11:0] >= 12'd32 && n < 5000) begin
            cyc();
            n++;
            nx = lfsr_step(m_lfsr);
        end
        if (n >= 5000) begin
            tests++;
            fails++;
            $display("FAIL %s/lfsr_wait: no short delay within %0d cycles", tag, n);
            return;
        end
        dly = (int'(DMIN) + int'(nx[11:0])) * int'(TICK);
        start_btn = 1'b1;
        cyc();
        start_btn = 1'b0;
        check({tag, "/arm"}, obs(), pk(1, 0, 0, 0, 3'b000, 12'h000));
        check_best({tag, "/arm"});

        ca = (v.cheat_at > dly) ? dly : v.cheat_at;
        for (int i = 0; i <= dly; i++) begin
            cyc();
            start_btn = 1'b0;
            check($sformatf("%s/wait%0d", tag, i), obs(), pk(0, 0, 0, 0, 3'b000, 12'h000));
            if (i == 1) start_btn = 1'b1;
            if (v.kind == K_CHEAT && i == ca) begin
                resp_btn = 1'b1;
                cyc();
                resp_btn  = 1'b0;
                start_btn = 1'b0;
                check({tag, "/cheat"}, obs(), pk(0, 0, 0, 0, v.exp_flags, v.exp_result));
                for (int j = 0; j < 3; j++) begin
                    cyc();
                    check({tag, "/cheat_hold"}, obs(), pk(0, 0, 0, 0, v.exp_flags, v.exp_result));
                end
                check_best({tag, "/cheat"});
                return;
            end
        end
        cyc();
        start_btn = 1'b0;
        check({tag, "/run_entry"}, obs(), pk(0, 1, 0, 1, 3'b000, 12'h000));

        if (v.kind == K_ABORT) begin
            #1 clr = 1'b1;
            #1;
            check({tag, "/abort_outs"}, obs(), 19'd0);
            check({tag, "/abort_best"}, {19'd0, best_valid, best}, 32'd0);
            m_best = '0;
            m_bv   = 1'b0;
            #2 clr = 1'b0;
            for (int j = 0; j < 4; j++) begin
                cyc();
                check({tag, "/abort_idle"}, obs(), 19'd0);
            end
            return;
        end

        start_btn = 1'b1;
        cyc();
        start_btn = 1'b0;
        check({tag, "/run_start_ignored"}, obs(), pk(0, 0, 0, 1, 3'b000, 12'h000));
        for (int j = 0; j < v.run_cycles; j++) begin
            cyc();
            check({tag, "/run_hold"}, obs(), pk(0, 0, 0, 1, 3'b000, 12'h000));
        end

        if (v.kind == K_TIMEOUT) begin
            {d2, d1, d0} = 12'h999;
            cyc();
            check({tag, "/timeout"}, obs(), pk(0, 0, 1, 0, v.exp_flags, v.exp_result));
            cyc();
            check({tag, "/timeout_hold"}, obs(), pk(0, 0, 0, 0, v.exp_flags, v.exp_result));
            check_best({tag, "/timeout"});
            return;
        end

        {d2, d1, d0} = v.digits;
        resp_btn = 1'b1;
        cyc();
        resp_btn = 1'b0;
        check({tag, "/stopping"}, obs(), pk(0, 0, 1, 1, 3'b000, 12'h000));
        done_in = (v.done_dly >= 1 && v.done_dly <= SWM);
        k = done_in ? v.done_dly - 1 : SWM - 1;
        start_btn = 1'b1;
        for (int j = 0; j < k; j++) begin
            cyc();
            start_btn = 1'b0;
            check({tag, "/stop_wait"}, obs(), pk(0, 0, 0, 1, 3'b000, 12'h000));
        end
        done_tick = done_in;
        cyc();
        done_tick = 1'b0;
        start_btn = 1'b0;
        check({tag, "/show"}, obs(), pk(0, 0, 0, 0, v.exp_flags, v.exp_result));
        cyc();
        check({tag, "/show_hold"}, obs(), pk(0, 0, 0, 0, v.exp_flags, v.exp_result));
        if (!m_bv || v.exp_result < m_best) begin
            m_best = v.exp_result;
            m_bv   = 1'b1;
        end
        check_best({tag, "/show"});
    endtask

    function automatic vec_t make_rand();
        vec_t v;
        v.kind       = int'($urandom_range(0, 2));
        v.digits     = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        v.run_cycles = int'($urandom_range(0, 4));
        v.done_dly   = int'($urandom_range(0, SWM + 2));
        v.cheat_at   = int'($urandom_range(0, 150));
        case (v.kind)
            K_RESP:    begin v.exp_flags = 3'b001; v.exp_result = v.digits; end
            K_TIMEOUT: begin v.exp_flags = 3'b010; v.exp_result = 12'h000;  end
            default:   begin v.exp_flags = 3'b100; v.exp_result = 12'h000;  end
        endcase
        return v;
    endfunction

    vec_t tbl[10];

    initial begin
        //            kind       digits   run dd  cheat  flags   result
        tbl[0] = '{K_RESP,    12'h250, 1,  1,  0,    3'b001, 12'h250};
        tbl[1] = '{K_RESP,    12'h180, 0,  3,  0,    3'b001, 12'h180};
        tbl[2] = '{K_RESP,    12'h300, 4,  0,  0,    3'b001, 12'h300};
        tbl[3] = '{K_RESP,    12'h047, 2,  2,  0,    3'b001, 12'h047};
        tbl[4] = '{K_CHEAT,   12'h000, 0,  0,  5,    3'b100, 12'h000};
        tbl[5] = '{K_TIMEOUT, 12'h000, 3,  0,  0,    3'b010, 12'h000};
        tbl[6] = '{K_CHEAT,   12'h000, 0,  0,  9999, 3'b100, 12'h000};
        tbl[7] = '{K_RESP,    12'h999, 1,  5,  0,    3'b001, 12'h999};
        tbl[8] = '{K_CHEAT,   12'h000, 0,  0,  0,    3'b100, 12'h000};
        tbl[9] = '{K_RESP,    12'h123, 0,  9,  0,    3'b001, 12'h123};

        m_best = '0;
        m_bv   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", obs(), 19'd0);
        check("reset_best", {19'd0, best_valid, best}, 32'd0);
        clr = 1'b0;
        cyc();
        check("idle_outs", obs(), 19'd0);

        for (int t = 0; t < 10; t++)
            run_trial(tbl[t], $sformatf("tbl%0d", t));

        run_trial('{K_ABORT, 12'h000, 0, 0, 0, 3'b000, 12'h000}, "abort");

        for (int t = 0; t < 25; t++)
            run_trial(make_rand(), $sformatf("rnd%0d", t));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
